multicycle_ctrl: RTL and testbench
==================================

MULTICYCLE_CTRL -- requirements
Module: multicycle_ctrl

Interface
REQ-001 Parameter FETCH_TIMEOUT, default 15: maximum FETCH cycles waiting for imem_ready_i; legal range 1..255.
REQ-002 clk_i  input  1  clock; all state changes on the rising edge.
REQ-003 rst_i  input  1  reset, asynchronous, active-low.
REQ-004 start_i  input  1  level; begins sequencing from IDLE.
REQ-005 stop_i  input  1  level; requests a return to IDLE at the next instruction boundary.
REQ-006 op_i  input  7  opcode field of the instruction register (instr[6:0]).
REQ-007 imem_ready_i  input  1  instruction memory has valid data this cycle.
REQ-008 imem_req_o  output  1  instruction fetch request.
REQ-009 ir_we_o  output  1  instruction register load strobe.
REQ-010 pc_we_o  output  1  PC update strobe (PC <= PC+4).
REQ-011 rf_we_o  output  1  register file write enable.
REQ-012 alu_src_o  output  1  0 = RS2 data, 1 = sign-extended immediate.
REQ-013 alu_op_o  output  2  ALUOp to ALU control.
REQ-014 busy_o  output  1  high in every state except IDLE.
REQ-015 state_o  output  3  current state encoding.
REQ-016 illegal_o  output  1  unrecognised opcode flag.
REQ-017 timeout_o  output  1  sticky fetch-timeout flag.
REQ-018 instr_cnt_o  output  32  count of retired instructions.

Function
REQ-019 States and encodings: IDLE=0, FETCH=1, DECODE=2, EXEC=3, WB=4, HALT=5. Codes 6 and 7 shall go to IDLE on the next edge.
REQ-020 All outputs are Moore outputs, decoded only from registered state and registered decode fields.
REQ-021 IDLE: go to FETCH when start_i=1; otherwise stay in IDLE.
REQ-022 FETCH: assert imem_req_o. When imem_ready_i=1, pulse ir_we_o for 1 cycle and go to DECODE.
REQ-023 FETCH timeout: a wait counter clears on FETCH entry. If it reaches FETCH_TIMEOUT with imem_ready_i still 0, set timeout_o and go to HALT. If ready arrives in the same cycle the counter reaches FETCH_TIMEOUT, ready wins.
REQ-024 DECODE: register op_i. Decoding:
- 0110011 (R-type): alu_op=10, alu_src=0, legal.
- 0010011 (I-type): alu_op=00, alu_src=1, legal.
- any other opcode: illegal.
DECODE always goes to EXEC.
REQ-025 EXEC: drive alu_op_o and alu_src_o from the decode registers; go to WB. alu_op_o and alu_src_o are held from EXEC through WB and are 0 in all other states.
REQ-026 WB:
- pc_we_o=1 for 1 cycle.
- rf_we_o=1 only if the instruction is legal.
- instr_cnt_o increments by 1 for legal instructions and saturates at 0xFFFFFFFF.
REQ-027 WB exit: go to IDLE if stop_i=1, else to FETCH. stop_i is ignored in all other states, so an instruction in flight always completes.
REQ-028 Every legal instruction takes 4 cycles plus the fetch wait cycles.
REQ-029 HALT is terminal. All strobes stay 0 and busy_o stays 1; only reset exits HALT.
REQ-030 illegal_o is set in EXEC for an illegal opcode. Its behaviour afterwards is defined in REQ-035/REQ-036.

Reset
REQ-031 When rst_i=0, immediately and asynchronously:
- state goes to IDLE.
- every output goes to 0, including instr_cnt_o, illegal_o and timeout_o.
- the wait counter and decode registers clear.
REQ-032 A reset asserted in any state, including mid-WB, aborts the instruction and produces no further pc_we_o or rf_we_o pulse.
REQ-033 The first active edge after reset release evaluates start_i normally.

Configuration
REQ-034 Macro MULTICYCLE_CTRL_HALT_ON_ILLEGAL_EN selects the illegal-opcode behaviour.
REQ-035 With the macro defined: an illegal opcode sets illegal_o sticky, EXEC goes to HALT, and neither pc_we_o nor rf_we_o is asserted.
REQ-036 Without the macro: an illegal opcode is a NOP. WB asserts pc_we_o only, instr_cnt_o is not incremented, and illegal_o is a 1-cycle pulse in EXEC.

Verification
REQ-037 Reset, then start_i=1 with imem_ready_i=1 tied and op=0110011 -> state sequence 1,2,3,4,1; alu_op_o=10 and alu_src_o=0 in EXEC/WB; rf_we_o and pc_we_o pulse in WB; instr_cnt_o=1.
REQ-038 op=0010011 with imem_ready_i delayed 3 cycles -> FETCH lasts 4 cycles; alu_src_o=1 and alu_op_o=00; instr retires 7 cycles after FETCH entry.
REQ-039 imem_ready_i held at 0 with FETCH_TIMEOUT=15 -> timeout_o=1 and state_o=5 after 15 FETCH cycles; state stays 5 until rst_i=0.
REQ-040 op=1111111, both macro settings:
- macro defined -> HALT, no pc_we_o.
- macro undefined -> one-cycle illegal_o pulse, pc_we_o only, instr_cnt_o unchanged.
REQ-041 stop_i=1 raised in DECODE -> instruction completes WB, then state_o=0 and busy_o=0.
REQ-042 rst_i=0 pulsed during WB -> outputs go to 0 immediately; instr_cnt_o=0; no strobe after the edge.

Source files
------------

// File: rtl/multicycle_ctrl.sv
// Multicycle instruction sequencer: IDLE/FETCH/DECODE/EXEC/WB/HALT with Moore, registered strobes.
// Define MULTICYCLE_CTRL_HALT_ON_ILLEGAL_EN to halt on an illegal opcode instead of treating it as a NOP.
module multicycle_ctrl #(
   parameter int unsigned FETCH_TIMEOUT = 15
) (
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic        start_i,
   input  logic        stop_i,
   input  logic [6:0]  op_i,
   input  logic        imem_ready_i,
   output logic        imem_req_o,
   output logic        ir_we_o,
   output logic        pc_we_o,
   output logic        rf_we_o,
   output logic        alu_src_o,
   output logic [1:0]  alu_op_o,
   output logic        busy_o,
   output logic [2:0]  state_o,
   output logic        illegal_o,
   output logic        timeout_o,
   output logic [31:0] instr_cnt_o
);

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_FETCH  = 3'd1,
      S_DECODE = 3'd2,
      S_EXEC   = 3'd3,
      S_WB     = 3'd4,
      S_HALT   = 3'd5
   } state_t;

   localparam logic [6:0] OP_R      = 7'b0110011;
   localparam logic [6:0] OP_I      = 7'b0010011;
   localparam logic [7:0] WAIT_LAST = 8'(FETCH_TIMEOUT - 1);

   state_t      state;
   logic [7:0]  wait_cnt;
   logic        dec_legal;
   logic        dec_alu_src;
   logic [1:0]  dec_alu_op;

   logic        op_legal;
   logic        op_alu_src;
   logic [1:0]  op_alu_op;

   always_comb begin
      op_legal   = 1'b0;
      op_alu_src = 1'b0;
      op_alu_op  = 2'b00;
      case (op_i)
         OP_R: begin
            op_legal  = 1'b1;
            op_alu_op = 2'b10;
         end
         OP_I: begin
            op_legal   = 1'b1;
            op_alu_src = 1'b1;
         end
         default: ;
      endcase
   end

   assign state_o = state;

   // Every output is a register loaded on the same edge as the state it belongs to.
   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         state       <= S_IDLE;
         wait_cnt    <= '0;
         dec_legal   <= 1'b0;
         dec_alu_src <= 1'b0;
         dec_alu_op  <= 2'b00;
         imem_req_o  <= 1'b0;
         ir_we_o     <= 1'b0;
         pc_we_o     <= 1'b0;
         rf_we_o     <= 1'b0;
         alu_src_o   <= 1'b0;
         alu_op_o    <= 2'b00;
         busy_o      <= 1'b0;
         illegal_o   <= 1'b0;
         timeout_o   <= 1'b0;
         instr_cnt_o <= '0;
      end else begin
         ir_we_o <= 1'b0;
         pc_we_o <= 1'b0;
         rf_we_o <= 1'b0;
         case (state)
            S_IDLE: begin
               if (start_i) begin
                  state      <= S_FETCH;
                  imem_req_o <= 1'b1;
                  busy_o     <= 1'b1;
                  wait_cnt   <= '0;
               end
            end
            S_FETCH: begin
               // Ready is tested first so it wins on the final wait cycle.
               if (imem_ready_i) begin
                  state      <= S_DECODE;
                  imem_req_o <= 1'b0;
                  ir_we_o    <= 1'b1;
               end else if (wait_cnt == WAIT_LAST) begin
                  state      <= S_HALT;
                  imem_req_o <= 1'b0;
                  timeout_o  <= 1'b1;
               end else begin
                  wait_cnt <= wait_cnt + 8'd1;
               end
            end
            S_DECODE: begin
               state       <= S_EXEC;
               dec_legal   <= op_legal;
               dec_alu_src <= op_alu_src;
               dec_alu_op  <= op_alu_op;
               alu_src_o   <= op_alu_src;
               alu_op_o    <= op_alu_op;
               if (!op_legal)
                  illegal_o <= 1'b1;
            end
            S_EXEC: begin
`ifdef MULTICYCLE_CTRL_HALT_ON_ILLEGAL_EN
               if (!dec_legal) begin
                  state     <= S_HALT;
                  alu_src_o <= 1'b0;
                  alu_op_o  <= 2'b00;
               end else begin
                  state   <= S_WB;
                  pc_we_o <= 1'b1;
                  rf_we_o <= 1'b1;
               end
`else
               state     <= S_WB;
               pc_we_o   <= 1'b1;
               rf_we_o   <= dec_legal;
               illegal_o <= 1'b0;
`endif
            end
            S_WB: begin
               alu_src_o <= 1'b0;
               alu_op_o  <= 2'b00;
               if (dec_legal && (instr_cnt_o != 32'hFFFF_FFFF))
                  instr_cnt_o <= instr_cnt_o + 32'd1;
               if (stop_i) begin
                  state  <= S_IDLE;
                  busy_o <= 1'b0;
               end else begin
                  state      <= S_FETCH;
                  imem_req_o <= 1'b1;
                  wait_cnt   <= '0;
               end
            end
            S_HALT: begin
               state <= S_HALT;
            end
            default: begin
               state      <= S_IDLE;
               imem_req_o <= 1'b0;
               busy_o     <= 1'b0;
               alu_src_o  <= 1'b0;
               alu_op_o   <= 2'b00;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Scoreboard bench for multicycle_ctrl: expected WB results are queued at issue and checked at WB.
module tb_multicycle_ctrl;

   localparam logic [6:0] OP_R   = 7'b0110011;
   localparam logic [6:0] OP_I   = 7'b0010011;
   localparam logic [6:0] OP_BAD = 7'b1111111;

   logic        clk_i = 1'b0;
   logic        rst_i;
   logic        start_i;
   logic        stop_i;
   logic [6:0]  op_i;
   logic        imem_ready_i;
   logic        imem_req_o;
   logic        ir_we_o;
   logic        pc_we_o;
   logic        rf_we_o;
   logic        alu_src_o;
   logic [1:0]  alu_op_o;
   logic        busy_o;
   logic [2:0]  state_o;
   logic        illegal_o;
   logic        timeout_o;
   logic [31:0] instr_cnt_o;

   multicycle_ctrl #(.FETCH_TIMEOUT(15)) dut (
      .clk_i(clk_i), .rst_i(rst_i), .start_i(start_i), .stop_i(stop_i), .op_i(op_i),
      .imem_ready_i(imem_ready_i), .imem_req_o(imem_req_o), .ir_we_o(ir_we_o),
      .pc_we_o(pc_we_o), .rf_we_o(rf_we_o), .alu_src_o(alu_src_o), .alu_op_o(alu_op_o),
      .busy_o(busy_o), .state_o(state_o), .illegal_o(illegal_o), .timeout_o(timeout_o),
      .instr_cnt_o(instr_cnt_o)
   );

   always #5 clk_i = ~clk_i;

   typedef struct {
      logic [1:0]  alu_op;
      logic        alu_src;
      logic        rf_we;
      logic        chk_alu;
      logic [31:0] cnt;
   } exp_t;

   exp_t        sb[$];
   int          n_checks = 0;
   int          n_errors = 0;
   logic [31:0] exp_cnt  = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk_i);
      #1;
   endtask

   // Expected WB behaviour straight from the opcode table.
   task automatic push_exp(input logic [6:0] op, input bit force_cnt, input logic [31:0] cnt);
      exp_t e;
      bit   legal;
      legal     = (op == OP_R) || (op == OP_I);
      e.alu_op  = (op == OP_R) ? 2'b10 : 2'b00;
      e.alu_src = (op == OP_I);
      e.rf_we   = legal;
      e.chk_alu = legal;
      if (legal) exp_cnt = exp_cnt + 1;
      if (force_cnt) exp_cnt = cnt;
      e.cnt = exp_cnt;
      sb.push_back(e);
   endtask

   // WB monitor: pops one expectation per pc_we pulse, checks the count one cycle later.
   initial begin
      exp_t        e;
      bit          pend = 1'b0;
      logic [31:0] pend_cnt = 0;
      forever begin
         @(posedge clk_i);
         #1;
         if (pend) begin
            check("cnt_after_wb", instr_cnt_o, pend_cnt);
            pend = 1'b0;
         end
         if (pc_we_o === 1'b1) begin
            check("wb_has_exp", 32'(sb.size() > 0), 1);
            if (sb.size() > 0) begin
               e = sb.pop_front();
               check("wb_state", state_o, 4);
               check("wb_rf_we", rf_we_o, e.rf_we);
               if (e.chk_alu) begin
                  check("wb_alu_op", alu_op_o, e.alu_op);
                  check("wb_alu_src", alu_src_o, e.alu_src);
               end
               pend     = 1'b1;
               pend_cnt = e.cnt;
            end
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int n;
      int fc;
      rst_i = 1'b0; start_i = 1'b0; stop_i = 1'b0; op_i = '0; imem_ready_i = 1'b0;
      repeat (2) @(posedge clk_i);
      #1;
      check("rst_state", state_o, 0);
      check("rst_busy", busy_o, 0);
      check("rst_req", imem_req_o, 0);
      check("rst_cnt", instr_cnt_o, 0);
      check("rst_timeout", timeout_o, 0);
      check("rst_illegal", illegal_o, 0);

      // R-type, ready tied high: 1,2,3,4,1
      rst_i = 1'b1; start_i = 1'b1; op_i = OP_R; imem_ready_i = 1'b1;
      push_exp(OP_R, 1'b0, 0);
      tick(); check("a_fetch", state_o, 1); check("a_req", imem_req_o, 1); check("a_busy", busy_o, 1);
      tick(); check("a_decode", state_o, 2); check("a_ir_we", ir_we_o, 1); check("a_req_off", imem_req_o, 0);
      tick(); check("a_exec", state_o, 3); check("a_exec_alu_op", alu_op_o, 2); check("a_exec_src", alu_src_o, 0);
      start_i = 1'b0; imem_ready_i = 1'b0; op_i = OP_I;
      push_exp(OP_I, 1'b0, 0);
      tick(); check("a_wb", state_o, 4);
      tick(); check("a_refetch", state_o, 1); check("a_cnt", instr_cnt_o, 1);

      // I-type, ready after 3 wait cycles, stop raised in DECODE
      n = 0; fc = 1;
      while (n < 20) begin
         imem_ready_i = (state_o == 3'd1) && (fc >= 4);
         if (state_o == 3'd2) stop_i = 1'b1;
         tick();
         n++;
         if (state_o == 3'd1) fc++;
         if (instr_cnt_o == 32'd2) break;
      end
      check("b_retire_cycles", n, 7);
      check("b_fetch_cycles", fc, 4);
      check("b_state_idle", state_o, 0);
      check("b_busy", busy_o, 0);
      stop_i = 1'b0; imem_ready_i = 1'b0;
      tick(); check("b_stay_idle", state_o, 0);

      // Illegal opcode
      start_i = 1'b1; op_i = OP_BAD; imem_ready_i = 1'b1; stop_i = 1'b1;
`ifndef MULTICYCLE_CTRL_HALT_ON_ILLEGAL_EN
      push_exp(OP_BAD, 1'b0, 0);
`endif
      tick(); start_i = 1'b0;
      tick(); check("c_decode", state_o, 2);
      tick(); check("c_exec", state_o, 3); check("c_illegal", illegal_o, 1);
`ifdef MULTICYCLE_CTRL_HALT_ON_ILLEGAL_EN
      tick(); check("c_halt", state_o, 5); check("c_no_pc", pc_we_o, 0); check("c_sticky", illegal_o, 1);
      check("c_halt_busy", busy_o, 1);
      tick(); check("c_halt_stay", state_o, 5); check("c_no_pc2", pc_we_o, 0);
      rst_i = 1'b0; tick(); check("c_rst_illegal", illegal_o, 0); check("c_rst_cnt", instr_cnt_o, 0);
      rst_i = 1'b1; exp_cnt = 0;
`else
      tick(); check("c_wb", state_o, 4); check("c_pulse_end", illegal_o, 0); check("c_pc", pc_we_o, 1);
      tick(); check("c_idle", state_o, 0); check("c_cnt", instr_cnt_o, exp_cnt);
`endif
      stop_i = 1'b0;

      // Ready arrives on the 15th (last) wait cycle: ready wins
      start_i = 1'b1; op_i = OP_R; imem_ready_i = 1'b0; stop_i = 1'b1;
      push_exp(OP_R, 1'b0, 0);
      tick(); start_i = 1'b0; check("f_fetch", state_o, 1);
      repeat (14) tick();
      check("f_cycle15", state_o, 1); check("f_no_timeout", timeout_o, 0);
      imem_ready_i = 1'b1;
      tick(); check("f_ready_wins", state_o, 2); check("f_timeout", timeout_o, 0);
      imem_ready_i = 1'b0;
      repeat (3) tick();
      check("f_idle", state_o, 0); check("f_cnt", instr_cnt_o, exp_cnt);

      // Reset pulsed mid-WB
      start_i = 1'b1; op_i = OP_R; imem_ready_i = 1'b1; stop_i = 1'b1;
      push_exp(OP_R, 1'b1, 0);
      repeat (4) tick();
      check("d_wb", state_o, 4);
      #2 rst_i = 1'b0;
      #1;
      check("d_async_pc", pc_we_o, 0); check("d_async_rf", rf_we_o, 0);
      check("d_async_state", state_o, 0); check("d_async_busy", busy_o, 0);
      check("d_async_cnt", instr_cnt_o, 0);
      imem_ready_i = 1'b0; stop_i = 1'b0;
      tick(); check("d_no_pc", pc_we_o, 0); check("d_no_rf", rf_we_o, 0);
      rst_i = 1'b1;
      tick(); check("d_first_edge_start", state_o, 1);

      // Fetch timeout
      start_i = 1'b0;
      n = 1;
      while ((state_o == 3'd1) && (n < 40)) begin
         tick();
         if (state_o == 3'd1) n++;
      end
      check("e_fetch_cycles", n, 15);
      check("e_halt", state_o, 5); check("e_timeout", timeout_o, 1);
      check("e_busy", busy_o, 1); check("e_req", imem_req_o, 0);
      start_i = 1'b1;
      for (int i = 0; i < 3; i++) begin
         tick(); check("e_halt_stay", state_o, 5);
      end
      rst_i = 1'b0;
      #1;
      check("e_rst_timeout", timeout_o, 0); check("e_rst_state", state_o, 0);
      start_i = 1'b0;
      tick(); rst_i = 1'b1;
      tick();

      check("sb_drain", sb.size(), 0);
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
